// File: rtl/krnl_partial_knn_local_uram_1r1w_pipe_if.sv
// Bus bundle for the partialKnn local 1R1W buffer.
// Groups the clear handshake, the read port (address0/ce0/q0/q0_valid) and the
// masked write port (address1/ce1/we1/d1).
//   master : the kernel datapath side (drives requests, receives read data)
//   slave  : the memory side
interface krnl_partial_knn_local_uram_1r1w_pipe_if #(
   parameter int DataWidth    = 256,
   parameter int WordWidth    = 32,
   parameter int AddressWidth = 11
);
   localparam int NumWords = DataWidth / WordWidth;

   logic                    clear;
   logic                    busy;
   logic [AddressWidth-1:0] address0;
   logic                    ce0;
   logic [DataWidth-1:0]    q0;
   logic                    q0_valid;
   logic [AddressWidth-1:0] address1;
   logic                    ce1;
   logic [NumWords-1:0]     we1;
   logic [DataWidth-1:0]    d1;

   modport master (
      output clear, address0, ce0, address1, ce1, we1, d1,
      input  busy, q0, q0_valid
   );

   modport slave (
      input  clear, address0, ce0, address1, ce1, we1, d1,
      output busy, q0, q0_valid
   );
endinterface

// File: rtl/krnl_partial_knn_local_uram_1r1w_pipe.sv
// Local search-point buffer for the partialKnn kernels: a 1R1W row memory with
// per-word write masking, a fixed-depth non-stalling read pipeline with a valid
// strobe, write-first forwarding for same-cycle read/write collisions, and a
// sequencer that zeroes the whole array one row per cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts a sweep and flushes pending reads
//   bus   : slave side of the bundle (clear/busy, read port 0, write port 1)
module krnl_partial_knn_local_uram_1r1w_pipe #(
   parameter int DataWidth    = 256,
   parameter int WordWidth    = 32,
   parameter int AddressRange = 2048,
   parameter int AddressWidth = 11,
   parameter int ReadLatency  = 2,
   parameter int ClearOnReset = 1
) (
   input  logic clk,
   input  logic reset,
   krnl_partial_knn_local_uram_1r1w_pipe_if.slave bus
);
   localparam int NumWords = DataWidth / WordWidth;
   localparam int IdxW     = (AddressRange > 1) ? $clog2(AddressRange) : 1;
   localparam logic [IdxW-1:0]         LastRow = IdxW'(AddressRange - 1);
   localparam logic [AddressWidth:0]   RangeEnd = (AddressWidth + 1)'(AddressRange);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state_q, state_d;
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            busy;

   logic [DataWidth-1:0] mem [AddressRange];

   logic                 rd_in_range, wr_in_range;
   logic [IdxW-1:0]      rd_idx, wr_idx;
   logic                 rd_accept, wr_accept, wr_hit;
   logic [DataWidth-1:0] rd_row;

   // Stage 0 holds the row sampled at the accept edge; stages 1..ReadLatency
   // delay it so q0 appears ReadLatency edges after the accept.
   logic [DataWidth-1:0] data_p [ReadLatency+1];
   logic [ReadLatency:0] vld_p;

   assign busy     = (state_q == CLEAR);
   assign bus.busy = busy;

   assign rd_in_range = ({1'b0, bus.address0} < RangeEnd);
   assign wr_in_range = ({1'b0, bus.address1} < RangeEnd);
   assign rd_idx      = bus.address0[IdxW-1:0];
   assign wr_idx      = bus.address1[IdxW-1:0];

   assign rd_accept = bus.ce0 && !busy;
   assign wr_accept = bus.ce1 && !busy && wr_in_range && (|bus.we1);
   assign wr_hit    = wr_accept && rd_in_range && (bus.address0 == bus.address1);

   // Clear sequencer
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= (ClearOnReset != 0) ? CLEAR : IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (bus.clear) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            // clear is deliberately not looked at here: a sweep never restarts
            if (ptr_q == LastRow) begin
               state_d = IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // Array write port: the sweep owns the port while busy, so user writes are
   // simply dropped then. A clear and a write on the same idle edge both land;
   // the sweep later zeroes that row anyway.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[ptr_q] <= '0;
      end else if (wr_accept) begin
         for (int w = 0; w < NumWords; w++) begin
            if (bus.we1[w]) mem[wr_idx][w*WordWidth +: WordWidth] <= bus.d1[w*WordWidth +: WordWidth];
         end
      end
   end

   // Write-first merge: words being written on the accept edge replace the
   // stored words; unmasked words keep the old contents.
   always_comb begin
      rd_row = '0;
      if (rd_in_range) rd_row = mem[rd_idx];
      if (wr_hit) begin
         for (int w = 0; w < NumWords; w++) begin
            if (bus.we1[w]) rd_row[w*WordWidth +: WordWidth] = bus.d1[w*WordWidth +: WordWidth];
         end
      end
   end

   // Read pipeline. Each stage's data only moves when its valid does, so the
   // last stage (q0) keeps the most recently delivered row. Only the output
   // stage data is cleared by reset; inner stages are qualified by vld_p.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p               <= '0;
         data_p[ReadLatency] <= '0;
      end else begin
         // stage 0: accept edge
         vld_p[0] <= rd_accept;
         if (rd_accept) data_p[0] <= rd_row;
         // stages 1..ReadLatency: delay line
         for (int k = 1; k <= ReadLatency; k++) begin
            vld_p[k] <= vld_p[k-1];
            if (vld_p[k-1]) data_p[k] <= data_p[k-1];
         end
      end
   end

   assign bus.q0       = data_p[ReadLatency];
   assign bus.q0_valid = vld_p[ReadLatency];
endmodule
